// File: rtl/vector_lane_pipe_pkg.sv
// rtl/vector_lane_pipe_pkg.sv - shared opcode type and default constants for the vector lane pipe
package vector_lane_pipe_pkg;

    localparam int DEF_ELEM_WIDTH = 32;
    localparam int DEF_NUM_ELEMS  = 4;
    localparam int DEF_PIPE_DEPTH = 3;
    localparam int DEF_NUM_VREG   = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_ADDS = 4'h2,
        OP_SUBS = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_MIN  = 4'h7,
        OP_MAX  = 4'h8,
        OP_MUL  = 4'h9
    } lane_opcode_t;

    // Encodings 4'hA..4'hF are reserved and flagged as illegal by the pipe.
    function automatic logic op_is_legal(input lane_opcode_t op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_AND,
            OP_OR, OP_XOR, OP_MIN, OP_MAX, OP_MUL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/vector_lane_pipe_alu.sv
// rtl/vector_lane_pipe_alu.sv - single-element combinational ALU used once per lane element
module lane_elem_alu
    import vector_lane_pipe_pkg::*;
#(
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
) (
    input  logic [ELEM_WIDTH-1:0] a,
    input  logic [ELEM_WIDTH-1:0] b,
    input  lane_opcode_t          op,
    output logic [ELEM_WIDTH-1:0] y
);

    localparam logic [ELEM_WIDTH-1:0] SMAX = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    localparam logic [ELEM_WIDTH-1:0] SMIN = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    // One extra sign bit lets overflow be detected as a mismatch of the top two bits.
    logic [ELEM_WIDTH:0] sum_ext;
    logic [ELEM_WIDTH:0] dif_ext;
    logic                a_lt_b;

    assign sum_ext = {a[ELEM_WIDTH-1], a} + {b[ELEM_WIDTH-1], b};
    assign dif_ext = {a[ELEM_WIDTH-1], a} - {b[ELEM_WIDTH-1], b};
    assign a_lt_b  = $signed(a) < $signed(b);

    // Operation select; reserved encodings yield zero.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = sum_ext[ELEM_WIDTH-1:0];
            OP_SUB:  y = dif_ext[ELEM_WIDTH-1:0];
            OP_ADDS: begin
                if (sum_ext[ELEM_WIDTH] != sum_ext[ELEM_WIDTH-1]) begin
                    y = sum_ext[ELEM_WIDTH] ? SMIN : SMAX;
                end else begin
                    y = sum_ext[ELEM_WIDTH-1:0];
                end
            end
            OP_SUBS: begin
                if (dif_ext[ELEM_WIDTH] != dif_ext[ELEM_WIDTH-1]) begin
                    y = dif_ext[ELEM_WIDTH] ? SMIN : SMAX;
                end else begin
                    y = dif_ext[ELEM_WIDTH-1:0];
                end
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MIN:  y = a_lt_b ? a : b;
            OP_MAX:  y = a_lt_b ? b : a;
            // Multiply in the result width, so only the low half of the product exists.
            OP_MUL:  y = a * b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vector_lane_pipe.sv
// rtl/vector_lane_pipe.sv - fixed-latency element-wise vector lane with writeback backpressure
module vector_lane_pipe
    import vector_lane_pipe_pkg::*;
#(
    parameter  int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter  int NUM_ELEMS  = DEF_NUM_ELEMS,
    parameter  int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter  int NUM_VREG   = DEF_NUM_VREG,
    localparam int LANE_WIDTH = NUM_ELEMS * ELEM_WIDTH,
    localparam int REG_IDX_W  = $clog2(NUM_VREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld,
    input  logic [LANE_WIDTH-1:0] data0,
    input  logic [LANE_WIDTH-1:0] data1,
    input  logic [REG_IDX_W-1:0]  vec_reg_in,
    input  lane_opcode_t          opcode,
    output logic                  busy,
    input  logic                  wb_ready,
    output logic                  result_vld,
    output logic [REG_IDX_W-1:0]  vec_reg_out,
    output logic [LANE_WIDTH-1:0] data_out,
    output logic                  illegal_op
);

    logic                  advance;

    logic                  op_vld_q,  op_vld_d;
    logic [LANE_WIDTH-1:0] op_a_q,    op_a_d;
    logic [LANE_WIDTH-1:0] op_b_q,    op_b_d;
    logic [REG_IDX_W-1:0]  op_tag_q,  op_tag_d;
    lane_opcode_t          op_code_q, op_code_d;

    logic [LANE_WIDTH-1:0] alu_y;

    logic [PIPE_DEPTH-1:0] stg_vld_q,  stg_vld_d;
    logic [PIPE_DEPTH-1:0] stg_ill_q,  stg_ill_d;
    logic [REG_IDX_W-1:0]  stg_tag_q  [PIPE_DEPTH];
    logic [REG_IDX_W-1:0]  stg_tag_d  [PIPE_DEPTH];
    logic [LANE_WIDTH-1:0] stg_data_q [PIPE_DEPTH];
    logic [LANE_WIDTH-1:0] stg_data_d [PIPE_DEPTH];

    // A presented result that writeback refuses freezes the whole pipe, bubbles included.
    assign busy    = stg_vld_q[PIPE_DEPTH-1] & ~wb_ready;
    assign advance = ~busy;

    for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_elem
        lane_elem_alu #(
            .ELEM_WIDTH(ELEM_WIDTH)
        ) u_alu (
            .a  (op_a_q[g*ELEM_WIDTH +: ELEM_WIDTH]),
            .b  (op_b_q[g*ELEM_WIDTH +: ELEM_WIDTH]),
            .op (op_code_q),
            .y  (alu_y[g*ELEM_WIDTH +: ELEM_WIDTH])
        );
    end

    // Operand register: captures an issue, payload only loads on a real issue.
    always_comb begin
        op_vld_d  = op_vld_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_tag_d  = op_tag_q;
        op_code_d = op_code_q;
        if (advance) begin
            op_vld_d = vld;
            if (vld) begin
                op_a_d    = data0;
                op_b_d    = data1;
                op_tag_d  = vec_reg_in;
                op_code_d = opcode;
            end
        end
    end

    // Result stages: stage 0 takes the ALU output, later stages only delay.
    // Payload moves only with a valid entry so the outputs keep their last value across bubbles.
    always_comb begin
        stg_vld_d  = stg_vld_q;
        stg_ill_d  = stg_ill_q;
        stg_tag_d  = stg_tag_q;
        stg_data_d = stg_data_q;
        if (advance) begin
            stg_vld_d[0] = op_vld_q;
            if (op_vld_q) begin
                stg_data_d[0] = alu_y;
                stg_tag_d[0]  = op_tag_q;
                stg_ill_d[0]  = ~op_is_legal(op_code_q);
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stg_vld_d[i] = stg_vld_q[i-1];
                if (stg_vld_q[i-1]) begin
                    stg_data_d[i] = stg_data_q[i-1];
                    stg_tag_d[i]  = stg_tag_q[i-1];
                    stg_ill_d[i]  = stg_ill_q[i-1];
                end
            end
        end
    end

    // State registers; reset drops every in-flight op immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_vld_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_tag_q   <= '0;
            op_code_q  <= OP_ADD;
            stg_vld_q  <= '0;
            stg_ill_q  <= '0;
            stg_tag_q  <= '{default: '0};
            stg_data_q <= '{default: '0};
        end else begin
            op_vld_q   <= op_vld_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_tag_q   <= op_tag_d;
            op_code_q  <= op_code_d;
            stg_vld_q  <= stg_vld_d;
            stg_ill_q  <= stg_ill_d;
            stg_tag_q  <= stg_tag_d;
            stg_data_q <= stg_data_d;
        end
    end

    assign result_vld  = stg_vld_q[PIPE_DEPTH-1];
    assign vec_reg_out = stg_tag_q[PIPE_DEPTH-1];
    assign data_out    = stg_data_q[PIPE_DEPTH-1];
    assign illegal_op  = stg_ill_q[PIPE_DEPTH-1];

endmodule

// File: doc/vector_lane_pipe.md
VECTOR_LANE_PIPE -- requirements
Module: vector_lane_pipe

Interface
REQ-001 Parameter ELEM_WIDTH, default 32: bit width of one element.
REQ-002 Parameter NUM_ELEMS, default 4: elements processed in parallel per operation; LANE_WIDTH = NUM_ELEMS*ELEM_WIDTH.
REQ-003 Parameter PIPE_DEPTH, default 3, legal range 1..8: fixed issue-to-result latency in cycles.
REQ-004 Parameter NUM_VREG, default 32: destination register count; REG_IDX_W = $clog2(NUM_VREG).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 vld  input  1  issue request from execution unit.
REQ-009 data0  input  LANE_WIDTH  operand A, element i at bits [i*ELEM_WIDTH +: ELEM_WIDTH].
REQ-010 data1  input  LANE_WIDTH  operand B, same packing.
REQ-011 vec_reg_in  input  REG_IDX_W  destination vector register tag.
REQ-012 opcode  input  lane_opcode_t  operation select.
REQ-013 busy  output  1  lane cannot accept an issue this cycle.
REQ-014 wb_ready  input  1  writeback accepts the current result.
REQ-015 result_vld  output  1  result valid at writeback.
REQ-016 vec_reg_out  output  REG_IDX_W  tag of the presented result.
REQ-017 data_out  output  LANE_WIDTH  element-wise result.
REQ-018 illegal_op  output  1  presented result came from an undefined opcode.

Function
REQ-019 Issue is accepted on a rising edge where vld=1 and busy=0; vld while busy=1 is ignored, and the issuer holds it.
REQ-020 busy = result_vld & ~wb_ready; combinational, no other source.
REQ-021 Pipeline is PIPE_DEPTH stages, each holding valid, tag, opcode-derived result and illegal flag; stall (busy=1) freezes all stages, including bubbles.
REQ-022 With no stall, an op accepted at edge N presents result_vld=1 after edge N+PIPE_DEPTH; back-to-back issue sustains one result per cycle.
REQ-023 A result retires on an edge where result_vld=1 and wb_ready=1; it then stays on the outputs for exactly that one cycle.
REQ-024 Opcodes: ADD, SUB (wrap modulo 2^ELEM_WIDTH); ADDS, SUBS (signed saturating to [-2^(ELEM_WIDTH-1), 2^(ELEM_WIDTH-1)-1]); AND, OR, XOR; MIN, MAX (signed); MUL (low ELEM_WIDTH bits of product).
REQ-025 Elements are independent: no carry, saturation or flag crosses an element boundary.
REQ-026 The result is computed in stage 1 from registered operands; later stages only delay. The full product is never stored.
REQ-027 An undefined opcode encoding produces data_out=0 and illegal_op=1, with normal latency and tag.
REQ-028 When result_vld=0, data_out, vec_reg_out and illegal_op hold their last values, and the checker treats them as don't-care.

Reset
REQ-029 Asserting reset clears every stage valid bit at once, discarding in-flight ops; result_vld=0, busy=0, data_out=0, vec_reg_out=0, illegal_op=0.
REQ-030 The first issue is accepted on the first rising edge after reset deassertion.

Structure
REQ-031 lane_opcode_t (4-bit enum) and the default parameter constants live in the shared vector package.
REQ-032 A sub-module lane_elem_alu, with one ELEM_WIDTH combinational ALU, is instantiated NUM_ELEMS times by a generate loop.

Verification
REQ-033 ADD, ELEM_WIDTH=32, A=0xFFFFFFFF/1/2/3, B=1 per element, tag 5, wb_ready=1 -> after 3 cycles result_vld=1, data_out elems 0/2/3/4, vec_reg_out=5.
REQ-034 ADDS with A=0x7FFFFFF0 and B=0x20 in all elems -> 0x7FFFFFFF; SUBS with A=0x80000001 and B=2 -> 0x80000000.
REQ-035 Issue 4 ops on consecutive cycles, then hold wb_ready=0 for 5 cycles -> busy=1 during the stall, outputs frozen, no op lost or duplicated, tags retire in order.
REQ-036 Assert reset while 2 ops are in flight -> result_vld never asserts for them; the next issue returns with normal latency.
REQ-037 Opcode 4'hF -> data_out=0, illegal_op=1 with the correct tag; the following valid MUL 3*5 -> 15, illegal_op=0.
REQ-038 Repeat REQ-033 with PIPE_DEPTH=1 and PIPE_DEPTH=8 -> latency is 1 and 8 cycles.
